// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
//   Shared types and constants for the shift-and-add 4x4 multiply unit.
//   - mul_state_t     : controller state encoding (IDLE, RUN, DONE)
//   - MUL_STEPS       : number of RUN cycles, one per multiplier bit
//   - CNT_LAST        : step counter value on the final RUN cycle
//   - partial_addend  : selects the multiplicand or zero for one partial product
// -----------------------------------------------------------------------------
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } mul_state_t;

   localparam int MUL_STEPS = 4;

   // The 2-bit step counter reaches this value on the last RUN cycle.
   localparam logic [1:0] CNT_LAST = 2'(MUL_STEPS - 1);

   // One partial product of a 4-bit multiply: the multiplicand when the
   // current multiplier bit is set, otherwise zero.
   function automatic logic [3:0] partial_addend(input logic [3:0] mcand,
                                                 input logic       mbit);
      return mbit ? mcand : 4'b0000;
   endfunction

endpackage

// File: rtl/fourbitFA.sv
// -----------------------------------------------------------------------------
// fourbitFA
//   4-bit ripple-carry adder built from four full-adder cells. This is the
//   adder shared with the ALU datapath; the multiply controller reuses it.
//
//   Ports
//     a     in   4  first operand
//     b     in   4  second operand
//     cin   in   1  carry in
//     sum   out  4  a + b + cin, low four bits
//     carry out  1  carry out of bit 3
// -----------------------------------------------------------------------------
module fourbitFA (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       carry
);

   logic [4:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign carry = c[4];

endmodule

// File: rtl/shiftadd_mul4_ctrl.sv
// -----------------------------------------------------------------------------
// shiftadd_mul4_ctrl
//   Sequential 4x4 unsigned multiplier. One fourbitFA is sequenced over four
//   RUN cycles, adding one partial product per cycle into a right-shifting
//   {hi, lo} accumulator. lo starts as the multiplier and is shifted out as
//   product bits are shifted in, so after four steps {hi, lo} = a * b.
//
//   Ports
//     clk        in   1  rising-edge clock
//     rst        in   1  synchronous active-high reset
//     in_valid   in   1  a/b valid this cycle
//     in_ready   out  1  operands accepted (IDLE only)
//     a          in   4  multiplicand, unsigned
//     b          in   4  multiplier, unsigned
//     out_valid  out  1  product valid (DONE only)
//     out_ready  in   1  consumer takes the product
//     product    out  8  {hi, lo}; meaningful only while out_valid
//     busy       out  1  high in RUN or DONE
// -----------------------------------------------------------------------------
module shiftadd_mul4_ctrl
   import mul_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] product,
   output logic       busy
);

   mul_state_t state;
   mul_state_t state_nxt;

   logic [3:0] a_reg;
   logic [3:0] hi;
   logic [3:0] lo;
   logic [1:0] cnt;

   logic [3:0] addend;
   logic [3:0] s;
   logic       c;

   // Shared adder: accumulator high nibble plus the current partial product.
   fourbitFA u_fa (
      .a     (hi),
      .b     (addend),
      .cin   (1'b0),
      .sum   (s),
      .carry (c)
   );

   // Handshake signals decode only from the registered state, so there is no
   // combinational path from in_valid/out_ready to any output.
   always_comb begin
      addend    = partial_addend(a_reg, lo[0]);
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == CNT_LAST) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // hi/lo are left untouched on leaving DONE, so product keeps the last
   // result until the next operation is accepted.
   assign product = {hi, lo};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_reg <= 4'h0;
         hi    <= 4'h0;
         lo    <= 4'h0;
         cnt   <= 2'd0;
      end else begin
         state <= state_nxt;
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= a;
                  hi    <= 4'h0;
                  lo    <= b;
                  cnt   <= 2'd0;
               end
            end
            RUN: begin
               // Shift the 5-bit sum right across {hi, lo}: the adder carry
               // lands in hi[3], so the 8-bit result can never overflow.
               hi  <= {c, s[3:1]};
               lo  <= {s[0], lo[3:1]};
               cnt <= cnt + 2'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shiftadd_mul4_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shiftadd_mul4_ctrl
//   Scoreboard bench for the shift-and-add multiplier. Accepted operands push
//   their expected product into a queue; a negedge monitor pops and compares
//   whenever out_valid rises and checks handshake timing and hold behaviour.
// -----------------------------------------------------------------------------
module tb_shiftadd_mul4_ctrl;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] a;
   logic [3:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] product;
   logic       busy;

   shiftadd_mul4_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] val;
      int         edge_i;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] cur_exp;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fails = 0;
   int         drv_timeouts = 0;
   logic       bp_random = 1'b0;
   logic       b2b_mode = 1'b0;
   logic       finish_req = 1'b0;

   // Acceptance side of the scoreboard: sampled at the edge itself, before
   // the DUT's state update becomes visible.
   always @(posedge clk) begin
      if (rst) begin
         sb.delete();
      end else if (in_valid && in_ready) begin
         sb.push_back('{cur_exp, cyc});
      end
      cyc = cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor
   logic       prev_ov = 1'b0;
   logic       prev_hs = 1'b0;
   logic       prev_rst = 1'b0;
   logic       armed = 1'b0;
   logic       fin_done = 1'b0;
   logic [7:0] hold_val = 8'h00;
   int         last_rise = 0;
   int         b2b_rises = 0;

   always @(negedge clk) begin
      exp_t e;
      if (prev_rst) begin
         chk("rst_in_ready",  32'(in_ready),  32'd1);
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_busy",      32'(busy),      32'd0);
         chk("rst_product",   32'(product),   32'h00);
         armed = 1'b1;
      end else if (armed && !rst) begin
         chk("busy_vs_in_ready", 32'(busy), 32'(!in_ready));
         if (prev_hs) begin
            chk("after_hs_out_valid", 32'(out_valid), 32'd0);
            chk("after_hs_in_ready",  32'(in_ready),  32'd1);
         end else if (prev_ov) begin
            chk("hold_out_valid", 32'(out_valid), 32'd1);
         end
         if (!b2b_mode) b2b_rises = 0;
         if (out_valid && !prev_ov) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fails++;
               $display("FAIL unexpected_result: got product 0x%0h, expected no result", product);
            end else begin
               e = sb.pop_front();
               chk("product", 32'(product), 32'(e.val));
               chk("latency", 32'(cyc - 1 - e.edge_i), 32'd4);
               hold_val = e.val;
               if (b2b_mode) begin
                  if (b2b_rises > 0) chk("b2b_interval", 32'(cyc - last_rise), 32'd6);
                  b2b_rises++;
               end
               last_rise = cyc;
            end
         end else if (out_valid && prev_ov) begin
            chk("stable_product", 32'(product), 32'(hold_val));
         end
      end
      if (finish_req && !fin_done) begin
         fin_done = 1'b1;
         chk("results_outstanding", 32'(sb.size()), 32'd0);
         chk("driver_timeouts", 32'(drv_timeouts), 32'd0);
         $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
         $finish;
      end
      prev_ov  = out_valid;
      prev_hs  = out_valid && out_ready;
      prev_rst = rst;
   end

   // Driver
   task automatic step();
      @(posedge clk);
      #1;
      if (bp_random) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic [3:0] av, input logic [3:0] bv, input logic [7:0] ev);
      logic acc;
      a        = av;
      b        = bv;
      cur_exp  = ev;
      in_valid = 1'b1;
      acc      = 1'b0;
      for (int k = 0; k < 64 && !acc; k++) begin
         acc = in_ready;
         step();
      end
      in_valid = 1'b0;
      if (!acc) drv_timeouts++;
   endtask

   task automatic wait_idle();
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
         if (in_ready && sb.size() == 0) ok = 1'b1;
         else step();
      end
      if (!ok) drv_timeouts++;
   endtask

   task automatic wait_out_valid();
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         if (out_valid) ok = 1'b1;
         else step();
      end
      if (!ok) drv_timeouts++;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = 4'h0;
      b         = 4'h0;
      out_ready = 1'b1;
      cur_exp   = 8'h00;
      repeat (3) step();
      rst = 1'b0;
      step();

      // Directed products, out_ready tied high
      send(4'hF, 4'hF, 8'hE1); wait_idle();
      send(4'h3, 4'h5, 8'h0F); wait_idle();
      send(4'h0, 4'h9, 8'h00); wait_idle();
      send(4'h9, 4'h0, 8'h00); wait_idle();
      send(4'h1, 4'h1, 8'h01); wait_idle();

      // Backpressure: DONE held for 10 cycles
      out_ready = 1'b0;
      send(4'hA, 4'h6, 8'h3C);
      wait_out_valid();
      repeat (10) step();
      out_ready = 1'b1;
      wait_idle();

      // in_valid held high with operands changing every cycle
      b2b_mode = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 24; i++) begin
         a       = 4'(i * 5 + 3);
         b       = 4'(i * 3 + 1);
         cur_exp = {4'h0, a} * {4'h0, b};
         step();
      end
      in_valid = 1'b0;
      wait_idle();
      b2b_mode = 1'b0;

      // Reset during the second RUN cycle of 7*7
      send(4'h7, 4'h7, 8'h31);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      send(4'h2, 4'h3, 8'h06); wait_idle();

      // Exhaustive sweep with random backpressure
      bp_random = 1'b1;
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            send(4'(ai), 4'(bi), 8'(ai * bi));
         end
      end
      wait_idle();
      bp_random = 1'b0;
      out_ready = 1'b1;

      finish_req = 1'b1;
      forever step();
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected completion within 50000 cycles");
      $fatal(1, "watchdog expired");
   end

endmodule
